regfile_wb_scheduler: RTL and testbench

Write-back scheduler and scoreboard for the 32 x 64-bit register file, which has a single write port. It arbitrates two write-back requesters (ALU, load unit) onto RW/BusW/RegWr using round-robin order. It also tracks destination registers reserved at issue, so issue logic can stall on RAW hazards until the data is actually in the file. Register 31 is hard zero and is never reserved or written.

---
 rtl/regfile_ctrl_pkg.sv | 7 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/regfile_wb_scheduler.sv | 99 +++++++++
 tb/tb_regfile_wb_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_ctrl_pkg.sv
// Shared register-file control constants for the write-back path and scoreboard.
package regfile_ctrl_pkg;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;
  localparam int NUM_REGS = 32;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; grant is combinational from req and last_grant.
// Under contention the requester that did not win last time is granted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  // 0: requester 0 won last, 1: requester 1 won last
  logic last_grant;

  assign grant[0] = req[0] && (!req[1] || last_grant);
  assign grant[1] = req[1] && (!req[0] || !last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (|grant) begin
      last_grant <= grant[1];
    end
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back arbiter, registered register-file write port and RAW scoreboard.
// Accept-to-RegWr is 1 cycle; Busy drops on the edge that ends the RegWr cycle.
module regfile_wb_scheduler #(
  parameter int DATA_W   = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W   = regfile_ctrl_pkg::ADDR_W,
  parameter int ZERO_REG = regfile_ctrl_pkg::ZERO_REG
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ResvValid,
  input  logic [ADDR_W-1:0] ResvReg,
  output logic              ResvReady,
  input  logic [ADDR_W-1:0] QueryA,
  input  logic [ADDR_W-1:0] QueryB,
  output logic              BusyA,
  output logic              BusyB,
  input  logic              Req0Valid,
  input  logic [ADDR_W-1:0] Req0Reg,
  input  logic [DATA_W-1:0] Req0Data,
  output logic              Req0Ready,
  input  logic              Req1Valid,
  input  logic [ADDR_W-1:0] Req1Reg,
  input  logic [DATA_W-1:0] Req1Data,
  output logic              Req1Ready,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic              RegWr,
  output logic              WbError
);
  localparam int NUM_REGS = regfile_ctrl_pkg::NUM_REGS;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [1:0]          req_vld;
  logic [1:0]          grant;
  logic                accept;
  logic [ADDR_W-1:0]   acc_reg;
  logic [DATA_W-1:0]   acc_data;
  logic                acc_real;

  assign req_vld = {Req1Valid, Req0Valid};

  rr_arbiter2 u_arb (
    .clk   (Clk),
    .reset (Reset),
    .req   (req_vld),
    .grant (grant)
  );

  assign Req0Ready = grant[0];
  assign Req1Ready = grant[1];
  assign accept    = |grant;
  assign acc_reg   = grant[1] ? Req1Reg  : Req0Reg;
  assign acc_data  = grant[1] ? Req1Data : Req0Data;
  assign acc_real  = accept && (acc_reg != ZERO_IDX);

  assign ResvReady = !busy[ResvReg] || (ResvReg == ZERO_IDX);
  assign BusyA     = (QueryA != ZERO_IDX) && busy[QueryA];
  assign BusyB     = (QueryB != ZERO_IDX) && busy[QueryB];

  // Clear is applied after set so a same-register collision resolves to clear;
  // in practice ResvReady already refused that reservation.
  always_comb begin
    busy_nxt = busy;
    if (ResvValid && ResvReady && (ResvReg != ZERO_IDX)) begin
      busy_nxt[ResvReg] = 1'b1;
    end
    if (RegWr) begin
      busy_nxt[RW] = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      RegWr   <= 1'b0;
      RW      <= '0;
      BusW    <= '0;
      WbError <= 1'b0;
    end else begin
      RegWr <= acc_real;
      if (accept) begin
        RW   <= acc_reg;
        BusW <= acc_data;
      end
      if (acc_real && !busy[acc_reg]) begin
        WbError <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench: stimulus pushes expected writes, a negedge monitor scores RW/BusW.
module tb_regfile_wb_scheduler;
  typedef struct {
    logic [4:0]  rw;
    logic [63:0] data;
  } wb_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ResvValid;
  logic [4:0]  ResvReg;
  logic        ResvReady;
  logic [4:0]  QueryA, QueryB;
  logic        BusyA, BusyB;
  logic        Req0Valid, Req1Valid;
  logic [4:0]  Req0Reg, Req1Reg;
  logic [63:0] Req0Data, Req1Data;
  logic        Req0Ready, Req1Ready;
  logic [4:0]  RW;
  logic [63:0] BusW;
  logic        RegWr;
  logic        WbError;

  int  tests = 0;
  int  fails = 0;
  wb_t exp_q[$];
  logic [4:0] r0_list [3];
  logic [4:0] r1_list [3];

  regfile_wb_scheduler dut (
    .Clk(Clk), .Reset(Reset),
    .ResvValid(ResvValid), .ResvReg(ResvReg), .ResvReady(ResvReady),
    .QueryA(QueryA), .QueryB(QueryB), .BusyA(BusyA), .BusyB(BusyB),
    .Req0Valid(Req0Valid), .Req0Reg(Req0Reg), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Reg(Req1Reg), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
    .RW(RW), .BusW(BusW), .RegWr(RegWr), .WbError(WbError)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] r, input logic [63:0] d);
    wb_t e;
    e.rw   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (RegWr === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wb_unexpected: RegWr=1 RW=%0d BusW=%0h, expected no write", RW, BusW);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_rw", 64'(RW), 64'(e.rw));
        check("wb_data", BusW, e.data);
      end
    end
  end

  task automatic reserve(input logic [4:0] r);
    ResvValid = 1'b1;
    ResvReg   = r;
    #1;
    check("resv_ready", 64'(ResvReady), 64'd1);
    @(negedge Clk);
    ResvValid = 1'b0;
    #1;
  endtask

  task automatic wr(input int port, input logic [4:0] r, input logic [63:0] d);
    if (port == 0) begin
      Req0Valid = 1'b1; Req0Reg = r; Req0Data = d;
    end else begin
      Req1Valid = 1'b1; Req1Reg = r; Req1Data = d;
    end
    #1;
    check("wr_ready0", 64'(Req0Ready), (port == 0) ? 64'd1 : 64'd0);
    check("wr_ready1", 64'(Req1Ready), (port == 1) ? 64'd1 : 64'd0);
    if (r != 5'd31) push(r, d);
    @(negedge Clk);
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1;
    ResvValid = 1'b0; ResvReg = '0;
    QueryA = 5'd5; QueryB = 5'd7;
    Req0Valid = 1'b0; Req0Reg = '0; Req0Data = '0;
    Req1Valid = 1'b0; Req1Reg = '0; Req1Data = '0;
    r0_list[0] = 5'd1; r0_list[1] = 5'd3; r0_list[2] = 5'd6;
    r1_list[0] = 5'd2; r1_list[1] = 5'd4; r1_list[2] = 5'd8;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    #1;

    // Reset state
    check("rst_regwr", 64'(RegWr), 64'd0);
    check("rst_rw", 64'(RW), 64'd0);
    check("rst_busw", BusW, 64'd0);
    check("rst_wberr", 64'(WbError), 64'd0);
    check("rst_busya", 64'(BusyA), 64'd0);
    check("rst_busyb", 64'(BusyB), 64'd0);
    check("rst_req0_ready", 64'(Req0Ready), 64'd0);

    // Single write to reserved R5
    reserve(5'd5);
    check("t1_busy_set", 64'(BusyA), 64'd1);
    wr(0, 5'd5, 64'hDEADBEEF);
    check("t1_regwr", 64'(RegWr), 64'd1);
    check("t1_busy_hold", 64'(BusyA), 64'd1);
    @(negedge Clk); #1;
    check("t1_busy_clr", 64'(BusyA), 64'd0);
    check("t1_regwr_low", 64'(RegWr), 64'd0);

    // Continuous contention from reset: Req0, Req1, Req0, Req1
    pulse_reset();
    for (int r = 1; r <= 4; r++) reserve(5'(r));
    begin
      int i0 = 0;
      int i1 = 0;
      for (int i = 0; i < 4; i++) begin
        Req0Valid = 1'b1; Req0Reg = r0_list[i0]; Req0Data = 64'h100 + 64'(r0_list[i0]);
        Req1Valid = 1'b1; Req1Reg = r1_list[i1]; Req1Data = 64'h200 + 64'(r1_list[i1]);
        #1;
        if (i > 0) check("t2_regwr_run", 64'(RegWr), 64'd1);
        check("t2_grant0", 64'(Req0Ready), (i % 2 == 0) ? 64'd1 : 64'd0);
        check("t2_grant1", 64'(Req1Ready), (i % 2 == 1) ? 64'd1 : 64'd0);
        if (i % 2 == 0) begin
          push(r0_list[i0], 64'h100 + 64'(r0_list[i0]));
          i0++;
        end else begin
          push(r1_list[i1], 64'h200 + 64'(r1_list[i1]));
          i1++;
        end
        @(negedge Clk);
      end
    end
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    QueryA = 5'd4; QueryB = 5'd1;
    #1;
    check("t2_regwr_last", 64'(RegWr), 64'd1);
    check("t2_busy4_hold", 64'(BusyA), 64'd1);
    check("t2_busy1_clr", 64'(BusyB), 64'd0);
    @(negedge Clk); #1;
    check("t2_regwr_end", 64'(RegWr), 64'd0);
    check("t2_busy4_clr", 64'(BusyA), 64'd0);

    // Write to hard-zero register
    QueryA = 5'd31;
    wr(1, 5'd31, 64'hBAD);
    check("t3_regwr", 64'(RegWr), 64'd0);
    check("t3_rw", 64'(RW), 64'd31);
    check("t3_wberr", 64'(WbError), 64'd0);
    check("t3_busy31", 64'(BusyA), 64'd0);

    // Reserve collides with the clear of the same register
    QueryA = 5'd7;
    reserve(5'd7);
    wr(0, 5'd7, 64'h7777);
    ResvValid = 1'b1; ResvReg = 5'd7;
    #1;
    check("t4_resv_refused", 64'(ResvReady), 64'd0);
    check("t4_busy_pre", 64'(BusyA), 64'd1);
    @(negedge Clk); #1;
    check("t4_resv_ok", 64'(ResvReady), 64'd1);
    check("t4_busy_clr", 64'(BusyA), 64'd0);
    @(negedge Clk);
    ResvValid = 1'b0;
    #1;
    check("t4_busy_reserved", 64'(BusyA), 64'd1);
    wr(0, 5'd7, 64'h7778);
    check("t4_wberr", 64'(WbError), 64'd0);
    @(negedge Clk); #1;
    check("t4_busy_final", 64'(BusyA), 64'd0);

    // Write to unreserved register sets sticky error
    wr(0, 5'd9, 64'h9999);
    check("t5_regwr", 64'(RegWr), 64'd1);
    check("t5_wberr", 64'(WbError), 64'd1);
    repeat (3) @(negedge Clk);
    #1;
    check("t5_wberr_sticky", 64'(WbError), 64'd1);

    // Reset in the cycle after an accept
    reserve(5'd10);
    reserve(5'd11);
    QueryA = 5'd10; QueryB = 5'd11;
    wr(0, 5'd10, 64'hAAAA);
    check("t6_busy11_pre", 64'(BusyB), 64'd1);
    pulse_reset();
    check("t6_regwr", 64'(RegWr), 64'd0);
    check("t6_wberr", 64'(WbError), 64'd0);
    check("t6_rw", 64'(RW), 64'd0);
    check("t6_busw", BusW, 64'd0);
    check("t6_busy10", 64'(BusyA), 64'd0);
    check("t6_busy11", 64'(BusyB), 64'd0);
    reserve(5'd12);
    reserve(5'd13);
    Req0Valid = 1'b1; Req0Reg = 5'd12; Req0Data = 64'hC12;
    Req1Valid = 1'b1; Req1Reg = 5'd13; Req1Data = 64'hC13;
    #1;
    check("t6_first_grant0", 64'(Req0Ready), 64'd1);
    check("t6_first_grant1", 64'(Req1Ready), 64'd0);
    push(5'd12, 64'hC12);
    @(negedge Clk);
    Req0Valid = 1'b0;
    #1;
    check("t6_second_grant1", 64'(Req1Ready), 64'd1);
    push(5'd13, 64'hC13);
    @(negedge Clk);
    Req1Valid = 1'b0;
    @(negedge Clk); #1;
    check("t6_wberr_end", 64'(WbError), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
